buffet_filler: RTL and testbench

Credit-gated fill engine; the producer end of the buffet Fill/credit protocol. It accepts a command (base address, word count), issues word reads to a backing memory, and pushes the returned words into a buffet in order. It consumes one credit per word and replenishes its count from the buffet's credit return. It never pushes more words than the buffet has announced free slots. It sits between the memory/DMA side and a buffet's push and credit ports.

---
 rtl/buffet_pkg.sv | 22 ++
 rtl/buffet_filler_if.sv | 55 +++++
 rtl/fifo.sv | 48 ++++
 rtl/buffet_filler.sv | 125 ++++++++++++
 tb/tb_buffet_filler.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/buffet_pkg.sv
// Shared definitions for the buffet filler.
// Contents: the FSM state encoding and helper functions that size the credit and
// in-flight counters from the block parameters.
package buffet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One extra bit so a full buffet (SIZE == 2**IDX_WIDTH) still fits.
  function automatic int credit_width(input int idx_width);
    return idx_width + 1;
  endfunction

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  function automatic int inflight_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/buffet_filler_if.sv
// Handshake bundle between the fill engine, its command source, the backing
// memory and the buffet push/credit ports.
//   master : fill-engine side (drives requests, pushes, cmd_ready, credit_ready)
//   slave  : environment side (command source, memory, buffet)
interface buffet_filler_if #(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int IDX_WIDTH      = 4
) ();
  logic [MEM_ADDR_WIDTH-1:0] cmd_addr_i;
  logic [LEN_WIDTH-1:0]      cmd_len_i;
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;

  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr_o;
  logic                      mem_req_valid_o;
  logic                      mem_req_ready_i;
  logic [DATA_WIDTH-1:0]     mem_resp_data_i;
  logic                      mem_resp_valid_i;
  logic                      mem_resp_ready_o;

  logic [DATA_WIDTH-1:0]     push_data;
  logic                      push_data_valid;
  logic                      push_data_ready;
  logic [IDX_WIDTH-1:0]      credit_out;
  logic                      credit_valid;
  logic                      credit_ready;

  modport master (
    input  cmd_addr_i, cmd_len_i, cmd_valid_i,
    output cmd_ready_o,
    output mem_req_addr_o, mem_req_valid_o,
    input  mem_req_ready_i,
    input  mem_resp_data_i, mem_resp_valid_i,
    output mem_resp_ready_o,
    output push_data, push_data_valid,
    input  push_data_ready,
    input  credit_out, credit_valid,
    output credit_ready
  );

  modport slave (
    output cmd_addr_i, cmd_len_i, cmd_valid_i,
    input  cmd_ready_o,
    input  mem_req_addr_o, mem_req_valid_o,
    output mem_req_ready_i,
    output mem_resp_data_i, mem_resp_valid_i,
    input  mem_resp_ready_o,
    input  push_data, push_data_valid,
    output push_data_ready,
    output credit_out, credit_valid,
    input  credit_ready
  );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with registered storage; read data comes straight from the
// head entry so it is stable while the reader stalls.
//   clk, reset_i              : clock, synchronous active-high reset
//   wr_data_i/valid_i/ready_o : write side, ready low when full
//   rd_data_o/valid_o/ready_i : read side, valid high when non-empty
// FIFO_DEPTH must be a power of 2 (pointers wrap naturally).
module fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           cnt_q;
  logic                  wr, rd;

  assign wr_ready_o = (cnt_q != (AW+1)'(FIFO_DEPTH));
  assign rd_valid_o = (cnt_q != '0);
  assign rd_data_o  = mem_q[rptr_q];
  assign wr         = wr_valid_i && wr_ready_o;
  assign rd         = rd_valid_o && rd_ready_i;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/buffet_filler.sv
// Credit-gated fill engine: takes (addr, len) commands, reads len words from the
// backing memory in address order and pushes them into a buffet, spending one
// credit per word request and replenishing from the buffet's credit return.
//   clk, reset_i : clock, synchronous active-high reset
//   bus          : command, memory request/response, buffet push and credit ports
//   busy_o       : engine not idle
//   done_o       : one-cycle pulse when a command has fully completed
module buffet_filler
  import buffet_pkg::*;
#(
  parameter int IDX_WIDTH       = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int SIZE            = 8,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  buffet_filler_if.master   bus,
  output logic              busy_o,
  output logic              done_o
);
  localparam int CREDIT_WIDTH   = credit_width(IDX_WIDTH);
  localparam int INFLIGHT_WIDTH = inflight_width(MAX_OUTSTANDING);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [CREDIT_WIDTH-1:0]   credits_q, credits_d;
  logic [INFLIGHT_WIDTH-1:0] inflight_q, inflight_d;
  logic                      done_q, done_d;
  logic                      req_hs, push_hs;

  // Request valid depends on registered state only; credits can only grow and
  // in-flight can only shrink without a handshake, so it holds once raised.
  assign bus.mem_req_valid_o = (state_q == RUN) && (credits_q != '0) &&
                               (inflight_q < INFLIGHT_WIDTH'(MAX_OUTSTANDING));
  assign bus.mem_req_addr_o  = addr_q;
  assign bus.cmd_ready_o     = (state_q == IDLE);
  assign bus.credit_ready    = 1'b1;
  assign busy_o              = (state_q != IDLE);
  // done_q covers zero-length commands; the DRAIN term fires the cycle after
  // the last push and is a single cycle because DRAIN then leaves to IDLE.
  assign done_o              = done_q || ((state_q == DRAIN) && (inflight_q == '0));

  assign req_hs  = bus.mem_req_valid_o && bus.mem_req_ready_i;
  assign push_hs = bus.push_data_valid && bus.push_data_ready;

  // In-flight is capped at the FIFO depth, so mem_resp_ready_o never drops
  // while a response is still owed.
  fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk        (clk),
    .reset_i    (reset_i),
    .wr_data_i  (bus.mem_resp_data_i),
    .wr_valid_i (bus.mem_resp_valid_i),
    .wr_ready_o (bus.mem_resp_ready_o),
    .rd_data_o  (bus.push_data),
    .rd_valid_o (bus.push_data_valid),
    .rd_ready_i (bus.push_data_ready)
  );

  always_comb begin
    credits_d = credits_q - CREDIT_WIDTH'(req_hs) +
                (bus.credit_valid ? CREDIT_WIDTH'(bus.credit_out) : '0);
    inflight_d = inflight_q;
    case ({req_hs, push_hs})
      2'b10:   inflight_d = inflight_q + INFLIGHT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - INFLIGHT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = bus.cmd_addr_i;
            rem_d   = bus.cmd_len_i;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (req_hs) begin
          addr_d = addr_q + MEM_ADDR_WIDTH'(1);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      credits_q  <= CREDIT_WIDTH'(SIZE);
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_buffet_filler.sv
// Scoreboard bench for buffet_filler: commands push their expected words into a
// queue, a monitor pops and compares on every push handshake. A small in-order
// memory model answers requests one cycle after they are accepted.
module tb_buffet_filler;
  localparam int IDX_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  localparam int SIZE = 8;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic reset_i;
  logic busy_o, done_o;

  buffet_filler_if #(.MEM_ADDR_WIDTH(32), .LEN_WIDTH(16), .DATA_WIDTH(DATA_WIDTH),
                     .IDX_WIDTH(IDX_WIDTH)) bus ();

  buffet_filler #(
    .IDX_WIDTH(IDX_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE),
    .MEM_ADDR_WIDTH(32), .LEN_WIDTH(16), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .reset_i(reset_i), .bus(bus), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int push_cnt = 0, req_cnt = 0, done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mq[$];
  logic [31:0] req_log[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: requests sampled at negedge take effect at the next posedge.
  initial begin
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (reset_i) mq.delete();
      else begin
        if (bus.mem_resp_valid_i && bus.mem_resp_ready_o) void'(mq.pop_front());
        if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
          mq.push_back(bus.mem_req_addr_o);
          req_log.push_back(bus.mem_req_addr_o);
          req_cnt++;
        end
      end
      @(posedge clk); #1;
      if (mq.size() != 0) begin
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = word_of(mq[0]);
      end else begin
        bus.mem_resp_valid_i = 1'b0;
      end
    end
  end

  // Monitor: push scoreboard, done counter, credit upper bound.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_i) exp_q.delete();
      else begin
        if (bus.push_data_valid && bus.push_data_ready) begin
          push_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL push_unexpected: got %0h expected none", bus.push_data);
          end else begin
            check("push_data", {32'h0, bus.push_data}, {32'h0, exp_q.pop_front()});
          end
        end
        if (done_o) done_cnt++;
        if (dut.credits_q > SIZE) begin
          n_chk++; n_fail++;
          $display("FAIL credit_bound: got %0d expected <= %0d", dut.credits_q, SIZE);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
    int n = 0;
    bus.cmd_addr_i = a; bus.cmd_len_i = l; bus.cmd_valid_i = 1'b1;
    while (!bus.cmd_ready_o && n < 100) begin cyc(1); n++; end
    if (!bus.cmd_ready_o) check("cmd_accept", 0, 1);
    else for (int i = 0; i < int'(l); i++) exp_q.push_back(word_of(a + 32'(i)));
    cyc(1);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic give_credit(input int c);
    bus.credit_out = IDX_WIDTH'(c); bus.credit_valid = 1'b1;
    cyc(1);
    bus.credit_valid = 1'b0; bus.credit_out = '0;
  endtask

  task automatic wait_done(input string name);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 200) begin cyc(1); n++; end
    check(name, 64'(done_cnt > start), 1);
  endtask

  task automatic wait_pushes(input int target);
    int n = 0;
    while (push_cnt < target && n < 200) begin cyc(1); n++; end
    check("wait_pushes", push_cnt, target);
  endtask

  localparam logic [31:0] WRAP_EXP [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

  initial begin
    int p0, d0, r0, l0;
    reset_i = 1'b1;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
    bus.mem_req_ready_i = 1'b1; bus.push_data_ready = 1'b1;
    bus.credit_out = '0; bus.credit_valid = 1'b0;
    cyc(3);
    reset_i = 1'b0;

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready_o, 1);
    check("rst_req_valid", bus.mem_req_valid_o, 0);
    check("rst_push_valid", bus.push_data_valid, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_credit_ready", bus.credit_ready, 1);
    check("rst_credits", dut.credits_q, SIZE);

    // Credit limit: 20 words with 8 credits. The buffet never frees more than
    // SIZE slots at once, so the 12 credits come back as 8 then 4.
    p0 = push_cnt; d0 = done_cnt; r0 = req_cnt;
    send_cmd(32'h100, 16'd20);
    cyc(40);
    check("cl_pushes", push_cnt - p0, 8);
    check("cl_reqs", req_cnt - r0, 8);
    check("cl_req_valid_low", bus.mem_req_valid_o, 0);
    check("cl_busy", busy_o, 1);
    check("cl_credits_empty", dut.credits_q, 0);
    give_credit(8);
    wait_pushes(p0 + 16);
    give_credit(4);
    wait_done("cl_done");
    cyc(3);
    check("cl_pushes_total", push_cnt - p0, 20);
    check("cl_done_once", done_cnt - d0, 1);
    check("cl_credits_end", dut.credits_q, 0);
    check("cl_idle", busy_o, 0);

    // Simultaneous consume and return
    give_credit(1);
    cyc(1);
    check("sim_credits_1", dut.credits_q, 1);
    bus.mem_req_ready_i = 1'b0;
    send_cmd(32'h200, 16'd2);
    check("sim_req_valid", bus.mem_req_valid_o, 1);
    check("sim_req_addr", bus.mem_req_addr_o, 32'h200);
    bus.mem_req_ready_i = 1'b1; bus.credit_valid = 1'b1; bus.credit_out = 4'd3;
    cyc(1);
    bus.mem_req_ready_i = 1'b0; bus.credit_valid = 1'b0; bus.credit_out = '0;
    check("sim_credits_3", dut.credits_q, 3);
    check("sim_req_addr2", bus.mem_req_addr_o, 32'h201);
    bus.mem_req_ready_i = 1'b1;
    wait_done("sim_done");
    check("sim_credits_end", dut.credits_q, 2);
    give_credit(6);
    cyc(1);
    check("sim_topup", dut.credits_q, SIZE);

    // Push backpressure: in-flight cap stops requests at 4, head word held
    bus.push_data_ready = 1'b0;
    r0 = req_cnt;
    send_cmd(32'h300, 16'd6);
    cyc(10);
    check("bp_reqs", req_cnt - r0, MAX_OUT);
    check("bp_req_valid_low", bus.mem_req_valid_o, 0);
    check("bp_push_valid", bus.push_data_valid, 1);
    check("bp_push_head", bus.push_data, word_of(32'h300));
    bus.push_data_ready = 1'b1;
    wait_done("bp_done");
    give_credit(6);

    // Address wrap
    l0 = req_log.size();
    send_cmd(32'hFFFF_FFFE, 16'd4);
    wait_done("wrap_done");
    check("wrap_nreq", req_log.size() - l0, 4);
    for (int i = 0; i < 4; i++)
      if (req_log.size() > l0 + i) check("wrap_addr", req_log[l0 + i], WRAP_EXP[i]);
    give_credit(4);
    cyc(1);

    // Zero length
    r0 = req_cnt;
    send_cmd(32'h400, 16'd0);
    check("zl_done_pulse", done_o, 1);
    check("zl_busy", busy_o, 0);
    cyc(1);
    check("zl_done_low", done_o, 0);
    cyc(3);
    check("zl_no_reqs", req_cnt - r0, 0);
    check("zl_credits", dut.credits_q, SIZE);

    // Mid-command reset
    send_cmd(32'h500, 16'd10);
    cyc(3);
    check("mr_busy_before", busy_o, 1);
    reset_i = 1'b1;
    cyc(1);
    reset_i = 1'b0;
    check("mr_busy", busy_o, 0);
    check("mr_credits", dut.credits_q, SIZE);
    check("mr_push_valid", bus.push_data_valid, 0);
    check("mr_cmd_ready", bus.cmd_ready_o, 1);
    check("mr_req_valid", bus.mem_req_valid_o, 0);

    // Recovery after reset
    send_cmd(32'h600, 16'd3);
    wait_done("rec_done");
    cyc(2);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
